// File: rtl/scalar_wb_pkg.sv
// Shared types and sizes for the scalar register-file writer.
// Queue entry layout and index-width helper.
package scalar_wb_pkg;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int REG_SIZE   = 8;
  localparam int REG_QTY    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int REG_IDX_W  = idx_w(REG_QTY);
  localparam int PTR_W      = idx_w(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef struct packed {
    logic                 live;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_SIZE-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/scalar_writeback_arbiter_fifo.sv
// ALU result queue with per-entry live bits.
// Entries whose rd matches a load are killed in place.
module wb_kill_fifo
  import scalar_wb_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push_i,
  input  logic [REG_IDX_W-1:0]                 push_rd_i,
  input  logic [REG_SIZE-1:0]                  push_data_i,
  input  logic                                 pop_i,
  input  logic                                 kill_i,
  input  logic [REG_IDX_W-1:0]                 kill_rd_i,
  input  logic                                 flush_i,
  output wb_entry_t                            head_o,
  output logic [CNT_W-1:0]                     count_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [FIFO_DEPTH-1:0]                live_o,
  output logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] rd_o
);

  wb_entry_t        mem_q [FIFO_DEPTH];
  wb_entry_t        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Expose live/rd of every slot; popped slots are always dead.
  always_comb begin
    live_o = '0;
    rd_o   = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      live_o[i] = mem_q[i].live;
      rd_o[i]   = mem_q[i].rd;
    end
  end

  // Next state: flush beats all; kill precedes push so the
  // same-cycle enqueue stays live.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_d[i].live = 1'b0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (kill_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++)
          if (mem_q[i].live && mem_q[i].rd == kill_rd_i)
            mem_d[i].live = 1'b0;
      end
      if (do_pop) begin
        mem_d[rd_q].live = 1'b0;
        rd_d = rd_q + 1'b1;
      end
      if (do_push) begin
        mem_d[wr_q].live = 1'b1;
        mem_d[wr_q].rd   = push_rd_i;
        mem_d[wr_q].data = push_data_i;
        wr_d = wr_q + 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Queue state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= mem_d[i];
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scalar_writeback_arbiter.sv
// Single write port arbiter: loads always win, ALU queued.
// Registered write outputs feed the scalar register file.
module scalar_writeback_arbiter
  import scalar_wb_pkg::*;
#(
  parameter int registerSize     = REG_SIZE,
  parameter int registerQuantity = REG_QTY,
  parameter int fifoDepth        = FIFO_DEPTH,
  localparam int regIdxW         = idx_w(registerQuantity)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         aluValid,
  output logic                         aluReady,
  input  logic [regIdxW-1:0]           aluRd,
  input  logic [registerSize-1:0]      aluData,
  input  logic                         memValid,
  input  logic [regIdxW-1:0]           memRd,
  input  logic [registerSize-1:0]      memData,
  input  logic                         flush,
  output logic                         regWrEn,
  output logic [regIdxW-1:0]           regToWrite,
  output logic [registerSize-1:0]      dataIn,
  output logic [registerQuantity-1:0]  busyRegs,
  output logic [$clog2(fifoDepth):0]   aluCount
);

  wb_entry_t                            head;
  logic                                 full;
  logic                                 empty;
  logic                                 push;
  logic                                 pop;
  logic [FIFO_DEPTH-1:0]                live;
  logic [FIFO_DEPTH-1:0][REG_IDX_W-1:0] ent_rd;
  logic                                 wen_q, wen_d;
  logic [regIdxW-1:0]                   wrd_q, wrd_d;
  logic [registerSize-1:0]              wdat_q, wdat_d;

  assign aluReady = !full;
  assign push     = aluValid && aluReady;
  assign pop      = !memValid && !empty && !flush;

  wb_kill_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_rd_i   (aluRd),
    .push_data_i (aluData),
    .pop_i       (pop),
    .kill_i      (memValid),
    .kill_rd_i   (memRd),
    .flush_i     (flush),
    .head_o      (head),
    .count_o     (aluCount),
    .full_o      (full),
    .empty_o     (empty),
    .live_o      (live),
    .rd_o        (ent_rd)
  );

  // Port select: load first, else queue head, else idle.
  always_comb begin
    wen_d  = 1'b0;
    wrd_d  = wrd_q;
    wdat_d = wdat_q;
    if (memValid) begin
      wen_d  = 1'b1;
      wrd_d  = memRd;
      wdat_d = memData;
    end else if (pop) begin
      wen_d  = head.live;
      wrd_d  = head.rd;
      wdat_d = head.data;
    end
  end

  // Write-port output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q  <= 1'b0;
      wrd_q  <= '0;
      wdat_q <= '0;
    end else begin
      wen_q  <= wen_d;
      wrd_q  <= wrd_d;
      wdat_q <= wdat_d;
    end
  end

  assign regWrEn    = wen_q;
  assign regToWrite = wrd_q;
  assign dataIn     = wdat_q;

  // Pending-write bitmap for decode hazard checks.
  always_comb begin
    busyRegs = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (live[i])
        busyRegs[ent_rd[i]] = 1'b1;
    if (memValid)
      busyRegs[memRd] = 1'b1;
  end

endmodule

// File: tb/tb_scalar_writeback_arbiter.sv
// Bench for scalar_writeback_arbiter: queue model plus
// directed scenarios with literal pins.
module tb_scalar_writeback_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       aluValid;
  logic       aluReady;
  logic [2:0] aluRd;
  logic [7:0] aluData;
  logic       memValid;
  logic [2:0] memRd;
  logic [7:0] memData;
  logic       flush;
  logic       regWrEn;
  logic [2:0] regToWrite;
  logic [7:0] dataIn;
  logic [7:0] busyRegs;
  logic [2:0] aluCount;

  int n_checks = 0;
  int n_pass   = 0;

  scalar_writeback_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .aluValid   (aluValid),
    .aluReady   (aluReady),
    .aluRd      (aluRd),
    .aluData    (aluData),
    .memValid   (memValid),
    .memRd      (memRd),
    .memData    (memData),
    .flush      (flush),
    .regWrEn    (regWrEn),
    .regToWrite (regToWrite),
    .dataIn     (dataIn),
    .busyRegs   (busyRegs),
    .aluCount   (aluCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    bit live;
    int rd;
    int data;
  } ent_t;

  ent_t q[$];
  bit   m_wen;
  int   m_rd;
  int   m_data;
  bit   armed = 0;
  logic [7:0] dut_rf [8];

  // Model: queue of pending ALU writes, loads take the port.
  always @(posedge clk) begin : model
    bit   rdy;
    ent_t e;
    if (reset) begin
      q.delete();
      m_wen  = 0;
      m_rd   = 0;
      m_data = 0;
      armed  = 1;
    end else begin
      rdy = (q.size() < 4);
      if (flush) begin
        m_wen = memValid;
        if (memValid) begin
          m_rd   = memRd;
          m_data = memData;
        end
        q.delete();
      end else begin
        if (memValid) begin
          m_wen  = 1;
          m_rd   = memRd;
          m_data = memData;
          foreach (q[i])
            if (q[i].rd == int'(memRd)) q[i].live = 0;
        end else if (q.size() > 0) begin
          e      = q.pop_front();
          m_wen  = e.live;
          m_rd   = e.rd;
          m_data = e.data;
        end else begin
          m_wen = 0;
        end
        if (aluValid && rdy)
          q.push_back('{1, int'(aluRd), int'(aluData)});
      end
    end
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin : compare
    logic [7:0] eb;
    if (armed) begin
      eb = '0;
      foreach (q[i])
        if (q[i].live) eb[q[i].rd] = 1'b1;
      if (memValid) eb[memRd] = 1'b1;
      chk("regWrEn",    regWrEn,    m_wen);
      chk("regToWrite", regToWrite, m_rd);
      chk("dataIn",     dataIn,     m_data);
      chk("aluCount",   aluCount,   q.size());
      chk("aluReady",   aluReady,   q.size() < 4);
      chk("busyRegs",   busyRegs,   eb);
      if (regWrEn) dut_rf[regToWrite] = dataIn;
    end
  end

  task automatic cyc(input bit av, input int ard, input int ad,
                     input bit mv, input int mrd, input int md,
                     input bit fl);
    aluValid = av;
    aluRd    = ard[2:0];
    aluData  = ad[7:0];
    memValid = mv;
    memRd    = mrd[2:0];
    memData  = md[7:0];
    flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (dut_rf[i]) dut_rf[i] = '0;
    reset = 1'b1;
    aluValid = 0; aluRd = 0; aluData = 0;
    memValid = 0; memRd = 0; memData = 0;
    flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",   regWrEn,  0);
    chk("rst_cnt",   aluCount, 0);
    chk("rst_busy",  busyRegs, 0);
    chk("rst_ready", aluReady, 1);
    chk("rst_data",  dataIn,   0);
    reset = 1'b0;

    // 1: three back-to-back ALU writes
    cyc(1, 1, 'h11, 0, 0, 0, 0);
    chk("t1_wen0", regWrEn, 0);
    chk("t1_cnt0", aluCount, 1);
    cyc(1, 2, 'h22, 0, 0, 0, 0);
    chk("t1_w1", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd1, 8'h11});
    chk("t1_cnt1", aluCount, 1);
    cyc(1, 3, 'h33, 0, 0, 0, 0);
    chk("t1_w2", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd2, 8'h22});
    idle();
    chk("t1_w3", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd3, 8'h33});
    chk("t1_cnt3", aluCount, 0);
    idle();
    chk("t1_hold", {regWrEn, dataIn}, {1'b0, 8'h33});

    // 2: fill under load pressure, then drain
    for (int i = 1; i <= 4; i++)
      cyc(1, i, 'hA0 + i, 1, 7, 'h70, 0);
    chk("t2_full_cnt", aluCount, 4);
    chk("t2_full_rdy", aluReady, 0);
    cyc(1, 6, 'hEE, 1, 7, 'h70, 0);
    chk("t2_hold_cnt", aluCount, 4);
    idle();
    chk("t2_p1", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd1, 8'hA1});
    chk("t2_rdy", aluReady, 1);
    chk("t2_cnt", aluCount, 3);
    repeat (3) idle();
    chk("t2_p4", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd4, 8'hA4});
    idle();
    chk("t2_end", {regWrEn, aluCount}, {1'b0, 3'd0});

    // 3: WAW kill
    cyc(1, 5, 'hAA, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 'hBB, 0);
    chk("t3_ld", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd5, 8'hBB});
    chk("t3_cnt", aluCount, 1);
    idle();
    chk("t3_kill_wen", regWrEn, 0);
    chk("t3_kill_cnt", aluCount, 0);
    idle();

    // 4: same-cycle ALU and load to r4
    cyc(1, 4, 'h01, 1, 4, 'h02, 0);
    chk("t4_ld", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd4, 8'h02});
    aluValid = 0;
    memValid = 0;
    #1;
    chk("t4_busy", busyRegs, 8'h10);
    idle();
    chk("t4_alu", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd4, 8'h01});
    chk("t4_busy0", busyRegs, 0);
    idle();

    // 5: flush with simultaneous load and enqueue
    for (int i = 1; i <= 3; i++)
      cyc(1, i, 'hC0 + i, 1, 7, 'h77, 0);
    chk("t5_cnt3", aluCount, 3);
    cyc(1, 1, 'hEE, 1, 6, 'h5C, 1);
    chk("t5_ld", {regWrEn, regToWrite, dataIn}, {1'b1, 3'd6, 8'h5C});
    chk("t5_cnt0", aluCount, 0);
    idle();
    chk("t5_nowr", regWrEn, 0);

    // 6: reset mid-operation
    cyc(1, 1, 'hD1, 1, 7, 'h77, 0);
    cyc(1, 2, 'hD2, 1, 7, 'h77, 0);
    chk("t6_cnt2", aluCount, 2);
    reset = 1'b1;
    cyc(1, 2, 'h99, 1, 3, 'h33, 0);
    reset = 1'b0;
    chk("t6_wen", regWrEn, 0);
    chk("t6_cnt", aluCount, 0);
    chk("t6_rdy", aluReady, 1);
    idle();
    chk("t6_after", regWrEn, 0);
    chk("t6_busy", busyRegs, 0);
    repeat (2) idle();

    chk("rf_r3", dut_rf[3], 8'hA3);
    chk("rf_r4", dut_rf[4], 8'h01);
    chk("rf_r5", dut_rf[5], 8'hBB);
    chk("rf_r6", dut_rf[6], 8'h5C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
